// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants, loader FSM states and the decoded-field
// bundle used between the loader top and its field packer.
package rv_enc_pkg;

  localparam int unsigned XLEN = 32;

  // Major opcodes the loader knows how to encode
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 values that turn OPC_IMM into an immediate shift
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // Decoded instruction fields as presented on the input stream
  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } inst_fields_t;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational RV32I packer: scatters decoded fields into a 32-bit word for
// R-, I- (load / ALU-imm / shift-imm) and S-type formats and flags whether the
// bundle is encodable.
//   fields : decoded instruction fields
//   word   : encoded instruction (NOP when illegal)
//   legal  : 1 when the opcode is supported and the immediate fits
module inst_field_pack
  import rv_enc_pkg::*;
(
  input  inst_fields_t    fields,
  output logic [XLEN-1:0] word,
  output logic            legal
);

  logic imm12_ok;
  logic shamt_ok;
  logic is_shift;

  // Immediate range checks: 12-bit signed range means bits 31..11 are a pure
  // sign extension; shift amounts must be 0..31.
  always_comb begin
    imm12_ok = (&fields.imm[31:11]) || (~|fields.imm[31:11]);
    shamt_ok = ~|fields.imm[31:5];
    is_shift = (fields.funct3 == F3_SLL) || (fields.funct3 == F3_SRL_SRA);
  end

  // Format selection by opcode
  always_comb begin
    word  = NOP_WORD;
    legal = 1'b0;
    case (fields.opcode)
      OPC_R: begin
        word  = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                 fields.rd, fields.opcode};
        legal = 1'b1;
      end
      OPC_LOAD: begin
        word  = {fields.imm[11:0], fields.rs1, fields.funct3,
                 fields.rd, fields.opcode};
        legal = imm12_ok;
      end
      OPC_IMM: begin
        if (is_shift) begin
          word  = {fields.funct7, fields.imm[4:0], fields.rs1, fields.funct3,
                   fields.rd, fields.opcode};
          legal = shamt_ok;
        end else begin
          word  = {fields.imm[11:0], fields.rs1, fields.funct3,
                   fields.rd, fields.opcode};
          legal = imm12_ok;
        end
      end
      OPC_STORE: begin
        word  = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                 fields.imm[4:0], fields.opcode};
        legal = imm12_ok;
      end
      default: begin
        word  = NOP_WORD;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: accepts decoded instruction bundles on a valid/ready
// stream, encodes them to RV32I words and writes them to consecutive imem
// word addresses starting at 0.
//   clk, rst                 : clock, async active-high reset
//   start                    : pulse, opens a load session from IDLE/DONE
//   in_valid/in_ready/in_last: bundle handshake, in_last closes the session
//   in_opcode..in_imm        : decoded instruction fields
//   imem_we/addr/wdata       : one-cycle imem write per legal bundle
//   busy, done, full, err    : session status
//   word_count               : words written in the current session
module inst_encoder_loader
  import rv_enc_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [XLEN-1:0]   in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned      CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CAPACITY  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  load_state_t     state;
  inst_fields_t    fields;
  logic [XLEN-1:0] enc_word;
  logic            enc_legal;
  logic            accept;
  logic            fills_last;

  // Bundle assembly for the packer
  always_comb begin
    fields        = '0;
    fields.opcode = in_opcode;
    fields.rd     = in_rd;
    fields.rs1    = in_rs1;
    fields.rs2    = in_rs2;
    fields.funct3 = in_funct3;
    fields.funct7 = in_funct7;
    fields.imm    = in_imm;
  end

  inst_field_pack u_pack (
    .fields (fields),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // word_count already includes the write in flight, so it alone bounds
  // the remaining capacity.
  assign in_ready   = (state == LOAD) && (word_count < CAPACITY);
  assign accept     = in_valid && in_ready;
  assign fills_last = enc_legal && (word_count == LAST_SLOT);

  // Session FSM with registered write port and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            word_count <= '0;
            imem_addr  <= '0;
            err        <= 1'b0;
            full       <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (enc_legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_count[ADDR_W-1:0];
              imem_wdata <= enc_word;
              word_count <= word_count + CNT_W'(1);
            end else begin
              err <= 1'b1;
            end
            if (fills_last) begin
              full <= 1'b1;
            end
            // done rises together with the final write; busy covers it
            if (in_last || fills_last) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= enc_legal;
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            word_count <= '0;
            imem_addr  <= '0;
            err        <= 1'b0;
            full       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Program loader for the single-cycle core. It takes decoded instruction fields (opcode, registers, funct, 32-bit immediate) over a valid/ready stream. It packs them into 32-bit RV32I words for R-, I- (load and ALU-imm) and S-type instructions, scattering the immediate into the format-specific bit positions. It then writes the words sequentially into instruction memory, and is used by test harnesses and bring-up to fill imem before the core leaves reset.

Parameters:
DEPTH, 256, number of 32-bit words in instruction memory (power of two).
ADDR_W, $clog2(DEPTH), word-address width of the imem write port.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a load session
in_valid  in  1  field bundle valid
in_ready  out  1  loader can accept a bundle this cycle
in_last  in  1  bundle is final instruction of the program
in_opcode  in  7  opcode
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2 (R/S only)
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R, and I-type shifts)
in_imm  in  32  sign-extended immediate (I/S)
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
busy  out  1  session active
done  out  1  session complete (level)
full  out  1  DEPTH words written
err  out  1  sticky: at least one bundle rejected
word_count  out  ADDR_W+1  words written this session

Behaviour:
- Reset (async, any time, including mid-session): state IDLE, all outputs 0, pending write dropped, counters cleared.
- FSM states:
  - IDLE -> LOAD on start.
  - LOAD -> DONE on the cycle after an accepted in_last bundle, or after the DEPTH-th write.
  - DONE -> LOAD on start. Entering LOAD clears word_count, address, err and full.
  - start in LOAD is ignored.
- in_ready = (state==LOAD) && (word_count + pending < DEPTH). Handshake is in_valid && in_ready. in_valid while not ready is ignored. Bundle fields must be held stable while in_valid and not in_ready.
- Latency: a bundle accepted at edge N produces imem_we=1 with addr/wdata for exactly one cycle after N. word_count increments at that same edge. Back-to-back accepts give one write per cycle at consecutive addresses starting at 0.
- Encoding, by opcode:
  - R (0110011): {funct7, rs2, rs1, funct3, rd, opc}.
  - I (0000011, 0010011): {imm[11:0], rs1, funct3, rd, opc}.
  - I-type shift (0010011 with funct3 001/101): {funct7, imm[4:0], rs1, funct3, rd, opc}.
  - S (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], opc}.
- Legality:
  - I/S: in_imm[31:11] must be all 0 or all 1.
  - Shifts: in_imm[31:5] must be 0.
  - Any other opcode is illegal.
  - An illegal bundle is consumed (handshake completes) but produces no write. It sets err, and word_count and address are unchanged.
  - An illegal bundle with in_last still ends the session.
- Full: after the DEPTH-th write, full=1, state DONE, in_ready=0. The address never wraps.
- busy = (state==LOAD) || pending write. done=1 only in DONE, asserted the same cycle as the final write.
- Simultaneous accept and final capacity slot: that write completes, then full.

Decomposition:
- Package rv_enc_pkg holds:
  - opcode constants OPC_R, OPC_LOAD, OPC_IMM, OPC_STORE;
  - funct3 shift constants;
  - NOP word 32'h00000013;
  - loader state enum (IDLE, LOAD, DONE).
- Sub-module inst_field_pack is purely combinational. It takes the fields and returns the encoded word plus a legal flag. The top holds the FSM, output register, address counter and flags.

Test Plan:
- start; addi x1,x2,-5 (opc 0010011, rd 1, rs1 2, f3 0, imm 32'hFFFFFFFB) with in_last -> next cycle imem_we=1, addr 0, wdata 32'hFFB10093, done=1, word_count=1.
- Back-to-back stream with in_valid held high:
  - add x3,x1,x2 -> 32'h002081B3 @0;
  - sub x3,x1,x2 (f7 0100000) -> 32'h402081B3 @1;
  - lw x4,-4(x1) -> 32'hFFC0A203 @2;
  - sw x5,8(x2) -> 32'h00512423 @3, last;
  - expect 4 writes on 4 consecutive cycles, word_count=4, err=0.
- Illegal bundles:
  - addi imm=2048 -> no write, err=1, word_count unchanged;
  - opcode 1100011 -> no write, err=1;
  - following legal bundle writes to the next unused address.
- DEPTH=4, 5 bundles offered with no in_last:
  - four writes at addr 0..3;
  - full=1, done=1, in_ready=0;
  - fifth bundle never accepted.
- Assert rst during LOAD with a write pending -> outputs 0 immediately, no imem_we. After release, a new start writes from addr 0.
- start in DONE after an errored session -> err, full and word_count clear; addresses restart at 0. start pulsed during LOAD has no effect.
